// File: rtl/fill_rect_engine.sv
// rtl/fill_rect_engine.sv - clipped rectangle framebuffer fill engine
//
// Walks a rectangle in raster order and issues one pixel write per accepted
// cycle. The rectangle is clipped to the visible area; an empty result is
// rejected with an err pulse and no writes.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start                 one-cycle request, sampled only while idle
//   x0, y0, x1, y1        inclusive rectangle corners
//   color_in              fill colour, latched together with the corners
//   wr_ready              write port accepts the presented write
//   busy, done, err       run status, done/err are single-cycle pulses
//   wr_en, wr_x, wr_y     write request and pixel coordinates
//   wr_addr, wr_data      linear address (wr_y*H_RES + wr_x) and colour
module fill_rect_engine #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COORD_W = 11,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               wr_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0]  H_STEP = ADDR_W'(H_RES);

    state_t state;
    state_t state_next;

    logic [COORD_W-1:0] lx0;
    logic [COORD_W-1:0] ly0;
    logic [COORD_W-1:0] lx1;
    logic [COORD_W-1:0] ly1;
    logic [COORD_W-1:0] x1c;
    logic [COORD_W-1:0] y1c;
    logic [ADDR_W-1:0]  row_base;
    logic [ADDR_W-1:0]  row_base_step;
    logic [ADDR_W-1:0]  setup_base;
    logic               reject;
    logic               accept;
    logic               row_end;
    logic               last_px;

    // Clipping against the visible area also rejects x0/y0 beyond the edge,
    // since the clipped corner can never exceed H_RES-1 / V_RES-1.
    assign x1c     = (lx1 > X_MAX) ? X_MAX : lx1;
    assign y1c     = (ly1 > Y_MAX) ? Y_MAX : ly1;
    assign reject  = (lx0 > x1c) || (ly0 > y1c);
    assign accept  = wr_en && wr_ready;
    assign row_end = (wr_x == x1c);
    assign last_px = row_end && (wr_y == y1c);

    // The only multiply: forms the first row base once, during SETUP.
    // Every later row advances the base by H_RES with an adder.
    assign setup_base    = ADDR_W'(ly0) * H_STEP;
    assign row_base_step = row_base + H_STEP;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SETUP;
            S_SETUP: state_next = reject ? S_IDLE : S_RUN;
            S_RUN:   if (accept && last_px) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        wr_en = 1'b0;
        done  = 1'b0;
        case (state)
            S_SETUP: busy = 1'b1;
            S_RUN: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lx0      <= '0;
            ly0      <= '0;
            lx1      <= '0;
            ly1      <= '0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            row_base <= '0;
            err      <= 1'b0;
        end else begin
            // err lands in the IDLE cycle right after a rejecting SETUP
            err <= (state == S_SETUP) && reject;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lx0     <= x0;
                        ly0     <= y0;
                        lx1     <= x1;
                        ly1     <= y1;
                        wr_data <= color_in;
                    end
                end
                S_SETUP: begin
                    if (!reject) begin
                        wr_x     <= lx0;
                        wr_y     <= ly0;
                        row_base <= setup_base;
                        wr_addr  <= setup_base + ADDR_W'(lx0);
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (!row_end) begin
                            wr_x    <= wr_x + COORD_W'(1);
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end else if (!last_px) begin
                            wr_x     <= lx0;
                            wr_y     <= wr_y + COORD_W'(1);
                            row_base <= row_base_step;
                            wr_addr  <= row_base_step + ADDR_W'(lx0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fill_rect_engine.sv
// tb/tb_fill_rect_engine.sv - self-checking bench for fill_rect_engine
module tb_fill_rect_engine;

    localparam int H  = 320;
    localparam int V  = 240;
    localparam int CW = 11;
    localparam int AW = 17;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] x0 = '0;
    logic [CW-1:0] y0 = '0;
    logic [CW-1:0] x1 = '0;
    logic [CW-1:0] y1 = '0;
    logic [DW-1:0] color_in = '0;
    logic          wr_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic          wr_en;
    logic [CW-1:0] wr_x;
    logic [CW-1:0] wr_y;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int tests_run = 0;
    int failed    = 0;

    int got_addr[$];
    int got_x[$];
    int got_y[$];
    int got_data[$];
    int exp_addr[$];
    int exp_x[$];
    int exp_y[$];

    int n_done, n_err, n_wren, busy_cycles, first_wr, done_cyc, err_cyc;
    int stab_bad, both_hi, timed_out;

    fill_rect_engine #(
        .H_RES(H), .V_RES(V), .COORD_W(CW), .ADDR_W(AW), .COLOR_W(DW)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_in(color_in),
        .wr_ready(wr_ready), .busy(busy), .done(done), .err(err),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clock = ~clock;

    // Reference: every pixel of the clipped rectangle in raster order.
    task automatic model_rect(input int ax0, input int ay0, input int ax1, input int ay1);
        int cx1, cy1;
        exp_addr.delete();
        exp_x.delete();
        exp_y.delete();
        cx1 = (ax1 > H - 1) ? H - 1 : ax1;
        cy1 = (ay1 > V - 1) ? V - 1 : ay1;
        for (int yy = ay0; yy <= cy1; yy++) begin
            for (int xx = ax0; xx <= cx1; xx++) begin
                exp_x.push_back(xx);
                exp_y.push_back(yy);
                exp_addr.push_back(yy * H + xx);
            end
        end
    endtask

    // Index of first difference between observed and model write lists, -1 if none.
    function automatic int seq_diff();
        int n;
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (got_addr[i] != exp_addr[i] || got_x[i] != exp_x[i] || got_y[i] != exp_y[i])
                return i;
        end
        if (got_addr.size() != exp_addr.size()) return n;
        return -1;
    endfunction

    function automatic int data_bad(input int col);
        int c = 0;
        foreach (got_data[i]) if (got_data[i] != col) c++;
        return c;
    endfunction

    // Starts one fill and records everything observed. Cycle 1 is the cycle
    // after the edge that samples start. mode: 0 ready always, 1 ready in a
    // 1,0,0 pattern from cycle 2, 2 random ready. restart_at drives a second
    // start in that cycle.
    task automatic do_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int col, input int mode, input int restart_at,
                           input int max_cycles);
        int n, post;
        logic prev_hold;
        logic [CW-1:0] px, py;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        got_addr.delete(); got_x.delete(); got_y.delete(); got_data.delete();
        n_done = 0; n_err = 0; n_wren = 0; busy_cycles = 0;
        first_wr = -1; done_cyc = -1; err_cyc = -1;
        stab_bad = 0; both_hi = 0; timed_out = 0;
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        color_in = DW'(col);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
        color_in = DW'($urandom);
        n = 1; post = -1; prev_hold = 1'b0;
        px = '0; py = '0; pa = '0; pd = '0;
        forever begin
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (n >= 2) && ((n - 2) % 3 == 0);
                default: wr_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = (n == restart_at);
            if (start) begin
                x0 = '0; y0 = '0; x1 = CW'(50); y1 = CW'(50);
            end
            if (busy) busy_cycles++;
            if (done) begin n_done++; if (done_cyc < 0) done_cyc = n; end
            if (err)  begin n_err++;  if (err_cyc < 0) err_cyc = n; end
            if (done && err) both_hi++;
            if (prev_hold && (wr_x !== px || wr_y !== py || wr_addr !== pa || wr_data !== pd))
                stab_bad++;
            prev_hold = wr_en && !wr_ready;
            px = wr_x; py = wr_y; pa = wr_addr; pd = wr_data;
            if (wr_en) begin n_wren++; if (first_wr < 0) first_wr = n; end
            if (wr_en && wr_ready) begin
                got_addr.push_back(int'(wr_addr));
                got_x.push_back(int'(wr_x));
                got_y.push_back(int'(wr_y));
                got_data.push_back(int'(wr_data));
            end
            if ((done || err) && post < 0) post = 0;
            if (post >= 0) post++;
            if (post > 3) break;
            if (n >= max_cycles) begin timed_out = 1; break; end
            @(posedge clock); #1;
            n++;
        end
        start = 1'b0;
        wr_ready = 1'b0;
        if (timed_out != 0) begin
            tests_run++; failed++;
            $display("FAIL fill_timeout rect (%0d,%0d)-(%0d,%0d): no done/err within %0d cycles",
                     ax0, ay0, ax1, ay1, max_cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++; if (busy !== 1'b0)  begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0)  begin failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++; if (err !== 1'b0)   begin failed++; $display("FAIL reset_err got %b want 0", err); end
        tests_run++; if (wr_en !== 1'b0) begin failed++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        tests_run++;
        if ({wr_x, wr_y, wr_addr, wr_data} !== '0) begin
            failed++;
            $display("FAIL reset_write_port got x=%0d y=%0d addr=%0d data=%0d want all 0",
                     wr_x, wr_y, wr_addr, wr_data);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_full_clear();
        int d;
        model_rect(0, 0, 319, 239);
        do_fill(0, 0, 319, 239, 8'h00, 0, -1, 77000);
        d = seq_diff();
        tests_run++;
        if (d != -1) begin
            failed++;
            $display("FAIL full_clear_seq first diff at %0d, got %0d writes want %0d",
                     d, got_addr.size(), exp_addr.size());
        end
        tests_run++; if (first_wr != 2) begin failed++; $display("FAIL full_clear_first_write got cycle %0d want 2", first_wr); end
        tests_run++; if (done_cyc != 76802) begin failed++; $display("FAIL full_clear_done_cycle got %0d want 76802", done_cyc); end
        tests_run++; if (n_done != 1 || n_err != 0) begin failed++; $display("FAIL full_clear_pulses got done=%0d err=%0d want 1/0", n_done, n_err); end
        tests_run++; if (data_bad(0) != 0) begin failed++; $display("FAIL full_clear_data got %0d wrong pixels want 0", data_bad(0)); end
    endtask

    task automatic test_backpressure();
        int d;
        model_rect(10, 5, 12, 6);
        do_fill(10, 5, 12, 6, 8'hA5, 1, -1, 200);
        d = seq_diff();
        tests_run++;
        if (d != -1) begin
            failed++;
            $display("FAIL subrect_seq first diff at %0d, got %0d writes want %0d",
                     d, got_addr.size(), exp_addr.size());
        end
        tests_run++; if (stab_bad != 0) begin failed++; $display("FAIL subrect_hold got %0d unstable cycles want 0", stab_bad); end
        tests_run++; if (n_done != 1 || done_cyc != 18) begin failed++; $display("FAIL subrect_done got %0d pulses at %0d want 1 at 18", n_done, done_cyc); end
        tests_run++; if (data_bad(8'hA5) != 0) begin failed++; $display("FAIL subrect_data got %0d wrong pixels want 0", data_bad(8'hA5)); end
    endtask

    task automatic test_clip();
        int d, col;
        col = int'($urandom_range(0, 255));
        model_rect(318, 238, 400, 300);
        do_fill(318, 238, 400, 300, col, 0, -1, 200);
        d = seq_diff();
        tests_run++;
        if (d != -1) begin
            failed++;
            $display("FAIL clip_seq first diff at %0d, got %0d writes want %0d",
                     d, got_addr.size(), exp_addr.size());
        end
        tests_run++; if (n_done != 1 || done_cyc != 6) begin failed++; $display("FAIL clip_done got %0d pulses at %0d want 1 at 6", n_done, done_cyc); end
    endtask

    task automatic test_reject();
        int rx0[2] = '{50, 320};
        int ry0[2] = '{10, 0};
        int rx1[2] = '{40, 330};
        int ry1[2] = '{20, 5};
        for (int k = 0; k < 2; k++) begin
            do_fill(rx0[k], ry0[k], rx1[k], ry1[k], 8'h3C, 0, -1, 50);
            tests_run++;
            if (n_err != 1 || err_cyc != 2) begin
                failed++;
                $display("FAIL reject%0d_err got %0d pulses at %0d want 1 at 2", k, n_err, err_cyc);
            end
            tests_run++;
            if (n_wren != 0 || n_done != 0) begin
                failed++;
                $display("FAIL reject%0d_quiet got wr_en=%0d done=%0d want 0/0", k, n_wren, n_done);
            end
            tests_run++;
            if (busy_cycles != 1) begin
                failed++;
                $display("FAIL reject%0d_busy got %0d cycles want 1", k, busy_cycles);
            end
        end
    endtask

    task automatic test_single_and_busy_start();
        int d;
        model_rect(0, 0, 0, 0);
        do_fill(0, 0, 0, 0, 8'h77, 0, -1, 50);
        d = seq_diff();
        tests_run++;
        if (d != -1 || done_cyc != 3) begin
            failed++;
            $display("FAIL single_pixel got %0d writes done at %0d want 1 write done at 3",
                     got_addr.size(), done_cyc);
        end
        model_rect(100, 50, 103, 53);
        do_fill(100, 50, 103, 53, 8'h12, 0, 5, 100);
        d = seq_diff();
        tests_run++;
        if (d != -1 || n_done != 1 || busy_cycles != 17) begin
            failed++;
            $display("FAIL start_while_busy got %0d writes %0d done %0d busy want 16/1/17",
                     got_addr.size(), n_done, busy_cycles);
        end
        do_fill(100, 50, 103, 53, 8'h12, 0, 18, 100);
        d = seq_diff();
        tests_run++;
        if (d != -1 || n_done != 1 || busy_cycles != 17) begin
            failed++;
            $display("FAIL start_in_done got %0d writes %0d done %0d busy want 16/1/17",
                     got_addr.size(), n_done, busy_cycles);
        end
    endtask

    task automatic test_reset_midrun();
        int cnt, active, d;
        logic hit;
        cnt = 0; hit = 1'b0; active = 0;
        x0 = '0; y0 = '0; x1 = CW'(319); y1 = CW'(239); color_in = 8'hFF;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (wr_en) cnt++;
            if (cnt == 100) begin hit = 1'b1; break; end
            @(posedge clock); #1;
        end
        tests_run++;
        if (!hit) begin
            failed++;
            $display("FAIL midrun_reach got %0d writes want 100", cnt);
        end
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL midrun_async got wr_en=%b busy=%b want 0/0", wr_en, busy);
        end
        wr_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (busy || wr_en || done || err) active++;
        end
        tests_run++;
        if (active != 0) begin
            failed++;
            $display("FAIL midrun_idle got %0d active cycles want 0", active);
        end
        model_rect(0, 0, 7, 2);
        do_fill(0, 0, 7, 2, 8'h5A, 0, -1, 100);
        d = seq_diff();
        tests_run++;
        if (d != -1 || first_wr != 2) begin
            failed++;
            $display("FAIL midrun_restart first diff %0d first write at %0d want -1 at 2", d, first_wr);
        end
    endtask

    task automatic test_random();
        int ax0, ay0, ax1, ay1, col, d, bad;
        for (int it = 0; it < 30; it++) begin
            ax0 = int'($urandom_range(0, 330));
            ay0 = int'($urandom_range(0, 245));
            ax1 = ax0 + int'($urandom_range(0, 10)) - 2;
            ay1 = ay0 + int'($urandom_range(0, 5)) - 1;
            if (ax1 < 0) ax1 = 0;
            if (ay1 < 0) ay1 = 0;
            col = int'($urandom_range(0, 255));
            model_rect(ax0, ay0, ax1, ay1);
            do_fill(ax0, ay0, ax1, ay1, col, 2, -1, 2000);
            d = seq_diff();
            if (exp_addr.size() == 0)
                bad = (n_err != 1 || n_wren != 0 || n_done != 0) ? 1 : 0;
            else
                bad = (d != -1 || n_done != 1 || n_err != 0 || stab_bad != 0 ||
                       data_bad(col) != 0) ? 1 : 0;
            if (both_hi != 0) bad = 1;
            tests_run++;
            if (bad != 0) begin
                failed++;
                $display("FAIL random%0d (%0d,%0d)-(%0d,%0d) got %0d writes done=%0d err=%0d hold=%0d diff=%0d want %0d writes",
                         it, ax0, ay0, ax1, ay1, got_addr.size(), n_done, n_err, stab_bad, d,
                         exp_addr.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_clear();
        test_backpressure();
        test_clip();
        test_reject();
        test_single_and_busy_start();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/fill_rect_engine.md
Name: fill_rect_engine

Overview:
Parametrised framebuffer fill engine; the successor to the fixed 320x240 clear sweeper. On a start pulse it walks an arbitrary clipped rectangle in raster order and issues one pixel write per accepted cycle (colour, x/y and linear address). A start/busy/done handshake drives it, and a ready input from the video-memory write port applies backpressure. It sits between the drawing/control FSM and the framebuffer write arbiter. It handles both full-screen clears and sub-region fills.

Parameters:
H_RES, 320, visible width in pixels
V_RES, 240, visible height in pixels
COORD_W, 11, width of x/y coordinates
ADDR_W, 17, width of linear framebuffer address (must hold H_RES*V_RES-1)
COLOR_W, 8, pixel data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
x0  in  COORD_W  rectangle left column, inclusive
y0  in  COORD_W  rectangle top row, inclusive
x1  in  COORD_W  rectangle right column, inclusive
y1  in  COORD_W  rectangle bottom row, inclusive
color_in  in  COLOR_W  fill colour
wr_ready  in  1  write port accepts current write
busy  out  1  high from SETUP through last write
done  out  1  one-cycle pulse after last accepted write
err  out  1  one-cycle pulse on rejected (empty) rectangle
wr_en  out  1  write request valid
wr_x  out  COORD_W  current pixel column
wr_y  out  COORD_W  current pixel row
wr_addr  out  ADDR_W  wr_y*H_RES + wr_x
wr_data  out  COLOR_W  latched colour

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. busy, done, err, wr_en, wr_x, wr_y, wr_addr and wr_data are all 0. Reset in the middle of a run aborts it; wr_en drops at reset assertion with no clock edge needed.
- States: IDLE -> SETUP -> RUN -> DONE -> IDLE. A rejected rectangle goes SETUP -> IDLE instead.
- IDLE: when start=1 at edge t, latch x0, y0, x1, y1 and color_in; the state becomes SETUP at t+1.
- SETUP (1 cycle, busy=1):
  - Clip: x1c = min(x1, H_RES-1), y1c = min(y1, V_RES-1).
  - Reject if x0>x1c or y0>y1c; this includes x0>=H_RES and y0>=V_RES.
  - On reject: pulse err for 1 cycle, return to IDLE, issue no writes.
  - Otherwise: load wr_x=x0, wr_y=y0, row_base=y0*H_RES and wr_addr=row_base+x0, then go to RUN.
  - y0*H_RES is formed by a shift-add or a one-time multiply in SETUP only. There is no per-pixel multiplier.
- RUN: wr_en=1 and busy=1. The first write is presented at cycle t+2.
  - Accept = wr_en && wr_ready. With wr_ready=0, hold wr_x, wr_y, wr_addr and wr_data stable.
  - On accept with wr_x<x1c: wr_x+1, wr_addr+1.
  - On accept with wr_x==x1c and wr_y<y1c: wr_x=x0, wr_y+1, row_base+=H_RES, wr_addr=row_base_next+x0.
  - On accept with wr_x==x1c and wr_y==y1c: go to DONE.
- DONE (1 cycle): done=1, busy=0, wr_en=0. Next state is IDLE. done and err are never high together.
- Write count: exactly (x1c-x0+1)*(y1c-y0+1) accepted writes, with no duplicate and no skipped address.
- Outside IDLE, start is ignored and latched parameters are unaffected. Changes on the x/y/color inputs after start have no effect.
- A start that arrives in the DONE cycle is ignored. The next start is accepted in IDLE.
- All arithmetic is unsigned. wr_addr never exceeds H_RES*V_RES-1.

Test Plan:
1. Full clear: x0=0, y0=0, x1=319, y1=239, color=0x00, wr_ready=1, start at t -> 76800 writes from t+2 to t+76801. Addresses run 0..76799 contiguously. The row wraps at x=319 to x=0 with y+1. done pulses at t+76802.
2. Sub-rect plus backpressure: (10,5)-(12,6), color=0xA5; wr_ready toggles 1,0,0,1... -> 6 accepted writes at addr 1610, 1611, 1612, 1930, 1931, 1932. Outputs hold stable while wr_ready=0. done pulses once.
3. Clipping: (318,238)-(400,300) -> 4 writes at (318,238), (319,238), (318,239), (319,239), i.e. addr 76478, 76479, 76798, 76799.
4. Reject: (50,10)-(40,20), then separately x0=320 -> err pulses at t+2 in each case, with no wr_en, no done, and busy high for one cycle only.
5. Single pixel and start while busy: (0,0)-(0,0) gives 1 write at addr 0. A second start during a 4x4 fill is ignored, so exactly 16 writes occur.
6. Reset mid-run: assert reset between clock edges during write 100 of a full clear -> wr_en and busy go 0 immediately. After release with no start, the block stays IDLE. A new start then begins again at addr 0.
